// File: rtl/mps_cpu_mc.sv
// mps_cpu_mc: multi-cycle MPS core with req/ack handshakes to instruction ROM and data RAM.
// Optional retired-instruction counter port is enabled by defining MPS_CPU_RETIRE_CNT_EN.
module mps_cpu_mc #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned IMEM_ADDR_WIDTH = 8,
  parameter int unsigned DMEM_ADDR_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       nreset,
  output logic                       imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [15:0]                imem_value,
  output logic                       dmem_req,
  output logic                       dmem_wenable,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]      dmem_wvalue,
  input  logic                       dmem_ack,
  input  logic [DATA_WIDTH-1:0]      dmem_rvalue,
  output logic                       halted,
  output logic                       fault
`ifdef MPS_CPU_RETIRE_CNT_EN
  ,
  output logic [31:0]                retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_SET   = 4'h2;
  localparam logic [3:0] OP_DUP   = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_BRZ   = 4'hA;
  localparam logic [3:0] OP_ILL0  = 4'hC;
  localparam logic [3:0] OP_ILL1  = 4'hE;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_LSH   = 4'h5;
  localparam logic [3:0] OP_RSH   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h9;
  localparam logic [3:0] OP_AND   = 4'hB;
  localparam logic [3:0] OP_XOR   = 4'hD;
  localparam logic [3:0] OP_NOT   = 4'hF;

  localparam logic [DATA_WIDTH-1:0] SHIFT_LIM = DATA_WIDTH'(DATA_WIDTH);

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [IMEM_ADDR_WIDTH-1:0]   r_pc;
  logic [15:0]                  r_ir;
  logic [DATA_WIDTH-1:0]        r_a;
  logic [DATA_WIDTH-1:0]        r_b;
  logic [DATA_WIDTH-1:0]        r_res;
  logic                         r_take;
  logic [DATA_WIDTH-1:0]        r_rf [16];

  logic                         r_imem_req;
  logic                         r_dmem_req;
  logic                         r_dmem_we;
  logic [DMEM_ADDR_WIDTH-1:0]   r_dmem_addr;
  logic [DATA_WIDTH-1:0]        r_dmem_wv;
  logic                         r_halted;
  logic                         r_fault;

  logic                         w_imem_req_nxt;
  logic                         w_dmem_req_nxt;
  logic                         w_dmem_we_nxt;
  logic [DMEM_ADDR_WIDTH-1:0]   w_dmem_addr_nxt;
  logic [DATA_WIDTH-1:0]        w_dmem_wv_nxt;
  logic                         w_halted_nxt;
  logic                         w_fault_nxt;

  logic [3:0]                   w_op;
  logic [3:0]                   w_rd;
  logic [3:0]                   w_ra_idx;
  logic [3:0]                   w_rb_idx;
  logic [7:0]                   w_imm;
  logic [DATA_WIDTH-1:0]        w_ra_val;
  logic [DATA_WIDTH-1:0]        w_rb_val;
  logic [DATA_WIDTH-1:0]        w_alu;
  logic                         w_is_mem;
  logic                         w_rd_we;
  logic                         w_imem_done;
  logic                         w_dmem_done;

  assign w_op     = r_ir[3:0];
  assign w_rd     = r_ir[7:4];
  assign w_ra_idx = r_ir[11:8];
  assign w_rb_idx = r_ir[15:12];
  assign w_imm    = r_ir[15:8];

  // r0 is hardwired to zero on the read side
  assign w_ra_val = (w_ra_idx == 4'd0) ? '0 : r_rf[w_ra_idx];
  assign w_rb_val = (w_rb_idx == 4'd0) ? '0 : r_rf[w_rb_idx];

  assign w_is_mem    = (w_op == OP_LOAD) || (w_op == OP_STORE);
  assign w_rd_we     = w_op[0] || (w_op == OP_SET) || (w_op == OP_DUP) || (w_op == OP_LOAD);
  assign w_imem_done = r_imem_req && imem_ack;
  assign w_dmem_done = r_dmem_req && dmem_ack;

  // State register
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_imem_done) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if ((w_op == OP_ILL0) || (w_op == OP_ILL1)) begin
          w_state_nxt = S_FAULT;
        end else if (w_op == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = w_is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (w_dmem_done) w_state_nxt = S_WB;
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FAULT;
    endcase
  end

  // Output decode from the upcoming state so the output flops line up with the state flop
  always_comb begin
    w_imem_req_nxt  = (w_state_nxt == S_FETCH);
    w_dmem_req_nxt  = (w_state_nxt == S_MEM);
    w_dmem_we_nxt   = 1'b0;
    w_dmem_addr_nxt = '0;
    w_dmem_wv_nxt   = '0;
    w_halted_nxt    = (w_state_nxt == S_HALT);
    w_fault_nxt     = (w_state_nxt == S_FAULT);
    if (w_state_nxt == S_MEM) begin
      w_dmem_we_nxt   = (w_op == OP_STORE);
      w_dmem_addr_nxt = DMEM_ADDR_WIDTH'(r_a);
      w_dmem_wv_nxt   = (w_op == OP_STORE) ? r_b : '0;
    end
  end

  // Result for every register-writing opcode except LOAD
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_LSH:  w_alu = (r_b >= SHIFT_LIM) ? '0 : (r_a << r_b);
      OP_RSH:  w_alu = (r_b >= SHIFT_LIM) ? '0 : (r_a >> r_b);
      OP_OR:   w_alu = r_a | r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_NOT:  w_alu = ~r_a;
      OP_SET:  w_alu = DATA_WIDTH'(w_imm);
      OP_DUP:  w_alu = r_a;
      default: w_alu = '0;
    endcase
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_imem_req  <= 1'b0;
      r_dmem_req  <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_dmem_addr <= '0;
      r_dmem_wv   <= '0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_imem_req  <= w_imem_req_nxt;
      r_dmem_req  <= w_dmem_req_nxt;
      r_dmem_we   <= w_dmem_we_nxt;
      r_dmem_addr <= w_dmem_addr_nxt;
      r_dmem_wv   <= w_dmem_wv_nxt;
      r_halted    <= w_halted_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  // Datapath: instruction latch, operand read, execute, memory capture, writeback
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_take <= 1'b0;
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_imem_done) r_ir <= imem_value;
        end
        S_DECODE: begin
          r_a <= w_ra_val;
          r_b <= w_rb_val;
        end
        S_EXEC: begin
          r_res  <= w_alu;
          r_take <= (w_op == OP_BRZ) && (r_a == '0);
        end
        S_MEM: begin
          if (w_dmem_done && !r_dmem_we) r_res <= dmem_rvalue;
        end
        S_WB: begin
          if (w_rd_we && (w_rd != 4'd0)) r_rf[w_rd] <= r_res;
          r_pc <= r_take ? IMEM_ADDR_WIDTH'(r_b) : (r_pc + IMEM_ADDR_WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

`ifdef MPS_CPU_RETIRE_CNT_EN
  logic [31:0] r_retired;

  // Counts writeback edges only; terminal states never pass through WB
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_retired <= '0;
    end else if (r_state == S_WB) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired = r_retired;
`endif

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign dmem_req     = r_dmem_req;
  assign dmem_wenable = r_dmem_we;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_wvalue  = r_dmem_wv;
  assign halted       = r_halted;
  assign fault        = r_fault;

endmodule

// File: tb/tb_mps_cpu_mc.sv
// tb_mps_cpu_mc: wait-state memory models, ISA-level reference model and scoreboard for mps_cpu_mc.
module tb_mps_cpu_mc;
  localparam int unsigned DW  = 8;
  localparam int unsigned IAW = 8;
  localparam int unsigned DAW = 8;

  logic           clock = 1'b0;
  logic           nreset = 1'b0;
  logic           imem_req;
  logic [IAW-1:0] imem_addr;
  logic           imem_ack = 1'b0;
  logic [15:0]    imem_value = '0;
  logic           dmem_req;
  logic           dmem_wenable;
  logic [DAW-1:0] dmem_addr;
  logic [DW-1:0]  dmem_wvalue;
  logic           dmem_ack = 1'b0;
  logic [DW-1:0]  dmem_rvalue = '0;
  logic           halted;
  logic           fault;
`ifdef MPS_CPU_RETIRE_CNT_EN
  logic [31:0]    retired;
`endif

  mps_cpu_mc #(.DATA_WIDTH(DW), .IMEM_ADDR_WIDTH(IAW), .DMEM_ADDR_WIDTH(DAW)) dut (
    .clock(clock), .nreset(nreset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_value(imem_value),
    .dmem_req(dmem_req), .dmem_wenable(dmem_wenable), .dmem_addr(dmem_addr),
    .dmem_wvalue(dmem_wvalue), .dmem_ack(dmem_ack), .dmem_rvalue(dmem_rvalue),
    .halted(halted), .fault(fault)
`ifdef MPS_CPU_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] addr; int gap; } fexp_t;
  typedef struct { logic we; logic [7:0] addr; logic [7:0] wv; } dexp_t;

  fexp_t       fq[$];
  dexp_t       dq[$];
  logic [15:0] rom [256];
  logic [7:0]  ram [256];
  int          model_ram [256];
  int          iwait, dwait;
  int          exp_end, exp_retired, exp_pc;
  bit          g_trunc;
  int          checks = 0, failures = 0, cyc = 0;
  string       cur_test = "none";
  logic [15:0] prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL [%s] %s: got 0x%0h expected 0x%0h (cycle %0d)", cur_test, name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb);
    return {rb, ra, rd, op};
  endfunction

  function automatic logic [15:0] set_i(input logic [3:0] rd, input logic [7:0] imm);
    return {imm, rd, 4'h2};
  endfunction

  // Reference ALU written with plain arithmetic on 0..255 integers
  function automatic int alu(input int op, input int a, input int b);
    case (op)
      1:  return (a + b) % 256;
      3:  return (a + 256 - b) % 256;
      5:  return (b >= 8) ? 0 : (a * (2 ** b)) % 256;
      7:  return (b >= 8) ? 0 : a / (2 ** b);
      9:  return a | b;
      11: return a & b;
      13: return a ^ b;
      default: return 255 - a;
    endcase
  endfunction

  // Executes the ROM instruction by instruction and queues the expected bus events
  task automatic run_model(input int max_instr);
    int r[16];
    int pc, n, a, b, res, npc, op, rd, ra, rb, imm;
    logic [15:0] w;
    bit stop, wr, was_mem;
    fexp_t fe;
    dexp_t de;
    foreach (r[k]) r[k] = 0;
    foreach (model_ram[k]) model_ram[k] = int'(ram[k]);
    pc = 0; n = 0; stop = 0; was_mem = 0;
    exp_end = 0; exp_retired = 0; g_trunc = 0; exp_pc = 0;
    while (!stop) begin
      if (n == max_instr) begin
        g_trunc = 1; stop = 1;
      end else begin
        w = rom[pc];
        op = int'(w[3:0]); rd = int'(w[7:4]); ra = int'(w[11:8]); rb = int'(w[15:12]);
        imm = int'(w[15:8]);
        fe.addr = 8'(pc);
        fe.gap = (n == 0) ? -1 : ((was_mem ? 5 + dwait : 4) + iwait);
        fq.push_back(fe);
        a = r[ra]; b = r[rb];
        npc = (pc + 1) % 256; wr = 0; was_mem = 0; res = 0; exp_pc = pc;
        case (op)
          0: begin exp_end = 1; stop = 1; end
          12, 14: begin exp_end = 2; stop = 1; end
          2: begin res = imm; wr = 1; end
          4: begin res = a; wr = 1; end
          6: begin
            res = model_ram[a]; wr = 1; was_mem = 1;
            de.we = 0; de.addr = 8'(a); de.wv = 8'h00; dq.push_back(de);
          end
          8: begin
            model_ram[a] = b; was_mem = 1;
            de.we = 1; de.addr = 8'(a); de.wv = 8'(b); dq.push_back(de);
          end
          10: if (a == 0) npc = b;
          default: begin res = alu(op, a, b); wr = 1; end
        endcase
        if (!stop) begin
          if (wr && rd != 0) r[rd] = res;
          exp_retired++; n++; pc = npc;
        end
      end
    end
  endtask

  // Instruction ROM: acks after iwait request cycles
  initial begin : imem_resp
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      imem_ack = 1'b0;
      if (imem_req === 1'b1) begin
        if (cnt >= iwait) begin
          imem_ack = 1'b1; imem_value = rom[imem_addr]; cnt = 0;
        end else begin
          cnt++; imem_value = 16'($urandom);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Data RAM: acks after dwait request cycles; read data is garbage except on ack
  initial begin : dmem_resp
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      dmem_ack = 1'b0;
      dmem_rvalue = 8'($urandom);
      if (dmem_req === 1'b1) begin
        if (cnt >= dwait) begin
          dmem_ack = 1'b1; cnt = 0;
          if (dmem_wenable) ram[dmem_addr] = dmem_wvalue;
          else dmem_rvalue = ram[dmem_addr];
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: pops the scoreboard on every completed handshake and checks bus discipline
  initial begin : monitor
    int last_fetch;
    logic pi, pd, pia, pda, ph, pf, hwe;
    logic [7:0] hia, hda, hdw;
    fexp_t fe;
    dexp_t de;
    last_fetch = -1; pi = 0; pd = 0; pia = 0; pda = 0; ph = 0; pf = 0;
    hwe = 0; hia = 0; hda = 0; hdw = 0;
    forever begin
      @(negedge clock); #1;
      if (nreset !== 1'b1) begin
        last_fetch = -1; pi = 0; pd = 0; pia = 0; pda = 0; ph = 0; pf = 0;
        continue;
      end
      if (pia) chk("imem_req_drop", 32'(imem_req), 0);
      if (pda) chk("dmem_req_drop", 32'(dmem_req), 0);
      if (imem_req && pi) chk("imem_addr_stable", 32'(imem_addr), 32'(hia));
      if (dmem_req && pd) begin
        chk("dmem_addr_stable", 32'(dmem_addr), 32'(hda));
        chk("dmem_we_stable", 32'(dmem_wenable), 32'(hwe));
        chk("dmem_wv_stable", 32'(dmem_wvalue), 32'(hdw));
      end
      if (!dmem_req) chk("dmem_idle_zero", {dmem_addr, dmem_wvalue}, 0);
      if (imem_req && imem_ack) begin
        if (fq.size() == 0) begin
          if (!g_trunc) begin
            checks++; failures++;
            $display("FAIL [%s] unexpected_fetch: addr 0x%0h with nothing expected", cur_test, imem_addr);
          end
        end else begin
          fe = fq.pop_front();
          chk("fetch_addr", 32'(imem_addr), 32'(fe.addr));
          if (fe.gap >= 0 && last_fetch >= 0) chk("fetch_gap", cyc - last_fetch, fe.gap);
        end
        last_fetch = cyc;
      end
      if (dmem_req && dmem_ack) begin
        if (dq.size() == 0) begin
          if (!g_trunc) begin
            checks++; failures++;
            $display("FAIL [%s] unexpected_dmem: addr 0x%0h with nothing expected", cur_test, dmem_addr);
          end
        end else begin
          de = dq.pop_front();
          chk("dmem_we", 32'(dmem_wenable), 32'(de.we));
          chk("dmem_addr", 32'(dmem_addr), 32'(de.addr));
          chk("dmem_wvalue", 32'(dmem_wvalue), 32'(de.wv));
        end
      end
      if (halted && !ph && last_fetch >= 0) chk("halt_latency", cyc - last_fetch, 2);
      if (fault && !pf && last_fetch >= 0) chk("fault_latency", cyc - last_fetch, 2);
      pi = imem_req && !imem_ack; pia = imem_req && imem_ack;
      pd = dmem_req && !dmem_ack; pda = dmem_req && dmem_ack;
      hia = imem_addr; hda = dmem_addr; hwe = dmem_wenable; hdw = dmem_wvalue;
      ph = halted; pf = fault;
    end
  end

  task automatic load_prog();
    foreach (rom[k]) rom[k] = 16'h0000;
    foreach (prog[k]) rom[k] = prog[k];
    foreach (ram[k]) ram[k] = 8'($urandom_range(1, 255));
  endtask

  task automatic run_prog(input string name, input int iw, input int dw, input int max_instr,
                          input int pulse_at);
    bit done;
    cur_test = name;
    nreset = 1'b0;
    @(negedge clock);
    iwait = iw; dwait = dw;
    @(negedge clock);
    fq.delete(); dq.delete();
    load_prog();
    run_model(max_instr);
    #2;
    chk("reset_outputs", {imem_req, imem_addr, dmem_req, dmem_wenable, dmem_addr, dmem_wvalue,
                          halted, fault}, 0);
    nreset = 1'b1;
    if (pulse_at > 0) begin
      repeat (pulse_at) @(negedge clock);
      nreset = 1'b0;
      @(negedge clock); #2;
      chk("midfetch_reset_outputs", {imem_req, imem_addr, dmem_req, dmem_wenable, dmem_addr,
                                     dmem_wvalue, halted, fault}, 0);
      fq.delete(); dq.delete();
      run_model(max_instr);
      nreset = 1'b1;
    end
    done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clock); #2;
      if (fq.size() == 0 && dq.size() == 0) begin
        if (exp_end == 1) done = (halted === 1'b1);
        else if (exp_end == 2) done = (fault === 1'b1);
        else done = 1;
      end
    end
    chk("completion", 32'(done), 1);
    if (!g_trunc) begin
      repeat (6) @(negedge clock);
      #2;
      chk("halted", 32'(halted), (exp_end == 1) ? 1 : 0);
      chk("fault", 32'(fault), (exp_end == 2) ? 1 : 0);
      chk("pc_frozen", 32'(imem_addr), exp_pc);
      chk("no_req_after_stop", {imem_req, dmem_req}, 0);
`ifdef MPS_CPU_RETIRE_CNT_EN
      chk("retired", retired, exp_retired);
`endif
    end
  endtask

  task automatic gen_random(input int len);
    int k;
    logic [3:0] op;
    prog.delete();
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(0, 17);
      if (k >= 13) begin
        prog.push_back(set_i(4'($urandom_range(0, 7)), 8'($urandom)));
      end else begin
        op = (k < 8) ? 4'(2 * k + 1) : 4'(2 * (k - 7));
        prog.push_back(ins(op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                           4'($urandom_range(0, 7))));
      end
    end
    prog.push_back(16'h0000);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    iwait = 0; dwait = 0;
    repeat (2) @(negedge clock);

    prog = '{set_i(1, 8'd5), set_i(2, 8'd3), ins(4'h1, 3, 1, 2), 16'h0000};
    run_prog("add_halt", 0, 0, 100, 0);

    prog = '{set_i(1, 8'd5), set_i(2, 8'd3), ins(4'h1, 3, 1, 2), set_i(7, 8'h40),
             ins(4'h8, 0, 7, 3), 16'h0000};
    run_prog("add_store", 0, 0, 100, 0);
    chk("r3_sum", 32'(ram[8'h40]), 8);

    prog = '{set_i(1, 8'hFF), set_i(2, 8'd1), ins(4'h1, 3, 1, 2), ins(4'h5, 4, 1, 2),
             set_i(5, 8'd9), ins(4'h7, 6, 1, 5), set_i(7, 8'h50), ins(4'h8, 0, 7, 3),
             set_i(7, 8'h51), ins(4'h8, 0, 7, 4), set_i(7, 8'h52), ins(4'h8, 0, 7, 6), 16'h0000};
    run_prog("wrap_shift", 1, 0, 100, 0);
    chk("add_wrap", 32'(ram[8'h50]), 32'h00);
    chk("lsh_ff", 32'(ram[8'h51]), 32'hFE);
    chk("rsh_over", 32'(ram[8'h52]), 32'h00);

    prog = '{set_i(1, 8'h10), set_i(2, 8'hAB), ins(4'h8, 0, 1, 2), ins(4'h6, 3, 1, 0),
             set_i(4, 8'h11), ins(4'h8, 0, 4, 3), 16'h0000};
    run_prog("mem_wait3", 0, 3, 100, 0);
    chk("store_data", 32'(ram[8'h10]), 32'hAB);
    chk("load_back", 32'(ram[8'h11]), 32'hAB);

    prog = '{set_i(1, 8'd0), set_i(2, 8'd6), ins(4'hA, 0, 1, 2), set_i(3, 8'd1), 16'h0000,
             16'h0000, set_i(0, 8'd7), ins(4'h4, 4, 0, 0), set_i(5, 8'h60),
             ins(4'h8, 0, 5, 4), 16'h0000};
    run_prog("brz_taken", 0, 0, 100, 0);
    chk("dup_r0", 32'(ram[8'h60]), 0);

    prog = '{set_i(1, 8'd1), set_i(2, 8'd6), ins(4'hA, 0, 1, 2), set_i(3, 8'h33),
             set_i(5, 8'h61), ins(4'h8, 0, 5, 3), 16'h0000};
    run_prog("brz_not_taken", 2, 1, 100, 0);
    chk("fallthrough", 32'(ram[8'h61]), 32'h33);

    prog = '{set_i(1, 8'd9), set_i(2, 8'd4), 16'h003C, set_i(3, 8'd1), 16'h0000};
    run_prog("illegal_c", 0, 0, 100, 0);

    prog = '{set_i(1, 8'd5), set_i(2, 8'd3), ins(4'h1, 3, 1, 2), 16'h0000};
    run_prog("reset_midfetch", 6, 0, 100, 13);

    for (int t = 0; t < 8; t++) begin
      gen_random($urandom_range(8, 20));
      run_prog($sformatf("random%0d", t), $urandom_range(0, 3), $urandom_range(0, 3), 60, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
